proc_controller: RTL and testbench
==================================

# proc_controller

Fetch/decode/execute controller for the ProjectB processor, sitting on the consumer side of the program counter. Drives the PC's `up`/`clear` controls, captures each 16-bit word returned by the instruction ROM into an internal instruction register (IR), and sequences the data memory, register file and ALU control strobes for each opcode. It is a Moore FSM. All datapath controls are decoded from the current state and the IR.

## Interface
- No parameters; all widths fixed.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `clear`  in  1  reset; synchronous, active-high.
- `instr`  in  16  instruction ROM read data; the ROM has a 1-cycle registered read of `pc_addr`.
- `pc_addr`  in  8  current PC value, used for status only.
- `pc_up`  out  1  increment request to the PC.
- `pc_clr`  out  1  clear request to the PC.
- `ir`  out  16  instruction register contents.
- `d_addr`  out  8  data memory address.
- `d_wr`  out  1  data memory write enable.
- `rf_s`  out  1  register file write-data select: 1 selects memory data, 0 selects the ALU result.
- `rf_w_addr`  out  4  register file write address.
- `rf_w_en`  out  1  register file write enable.
- `rf_ra_addr`  out  4  register file read port A address.
- `rf_rb_addr`  out  4  register file read port B address.
- `alu_s0`  out  3  ALU function: 0 = pass A, 1 = A+B, 2 = A−B.
- `state`  out  4  current state encoding, for the hex display.
- `halted`  out  1  high while in HALT.

## Operation
- State encodings:
  - INIT = 0, WAIT = 1, FETCH = 2, DECODE = 3
  - NOOP = 4, LOAD_A = 5, LOAD_B = 6, STORE = 7
  - ADD = 8, SUB = 9, HALT = 10, FWAIT = 11
  - Codes 12–15 are unused and return to INIT on the next edge.
- Opcode field is `ir[15:12]`:
  - 0 NOOP, 1 STORE, 2 LOAD, 3 ADD, 4 SUB, 5 HALT.
  - Opcodes 6–15 execute as NOOP.
- State transitions:
  - INIT → WAIT → FETCH.
  - FETCH → DECODE.
  - DECODE → the opcode's execute state.
  - LOAD_A → LOAD_B.
  - NOOP, LOAD_B, STORE, ADD and SUB → FETCH.
  - HALT → HALT until `clear`.
- Per-state outputs. Every output not listed is 0.
  - INIT: `pc_clr`=1.
  - FETCH: `pc_up`=1. The IR loads `instr` on the closing edge of FETCH.
  - STORE:
    - `d_addr`=`ir[11:4]`, `rf_ra_addr`=`ir[3:0]`, `alu_s0`=0, `d_wr`=1.
  - LOAD_A:
    - `d_addr`=`ir[11:4]`, `rf_s`=1, `rf_w_addr`=`ir[3:0]`.
  - LOAD_B: same as LOAD_A, plus `rf_w_en`=1.
  - ADD:
    - `rf_ra_addr`=`ir[11:8]`, `rf_rb_addr`=`ir[7:4]`, `rf_w_addr`=`ir[3:0]`, `alu_s0`=1, `rf_w_en`=1.
  - SUB: same as ADD, but `alu_s0`=2.
  - HALT: `halted`=1.
- The IR loads only on the closing edge of FETCH and holds its value in every other state.
- The execute state is selected from the IR value loaded at the end of FETCH.
- `ir` and `state` are registered outputs. All other outputs are combinational from `state` and `ir`.
- `pc_addr` is not used in the next-state logic.

## Timing
- Reset: `clear` high at a rising edge sets state to INIT and the IR to 16'h0000.
  - The edge that samples `clear` low moves the FSM from INIT to WAIT.
  - While `clear` is held high, the FSM stays in INIT with `pc_clr`=1; every other output is 0.
  - `clear` mid-instruction aborts the instruction at the next edge. `d_wr` and `rf_w_en` are 0 from that cycle on.
- ROM alignment:
  - The PC changes at the end of FETCH.
  - The ROM samples the new address at the end of DECODE.
  - `instr` is therefore valid from the first execute cycle and remains valid until the next FETCH.
  - The WAIT state after INIT covers the ROM latency for address 0.
- Cycles per instruction, FETCH through the last execute cycle:
  - NOOP, STORE, ADD, SUB: 3.
  - LOAD: 4.
- PC wrap-around from 255 to 0 is the PC's behaviour. The controller keeps fetching without special handling.
- HALT is entered with the PC already advanced past the HALT word. No further `pc_up` pulses occur.

## Configuration
- `FETCH_WAIT_EN` defined: supports a 2-cycle-latency ROM.
  - The FWAIT state (code 11, all outputs 0) is inserted before every FETCH.
  - INIT → WAIT → FWAIT → FETCH.
  - NOOP, LOAD_B, STORE, ADD and SUB → FWAIT → FETCH.
  - Each instruction takes 1 extra cycle.
- `FETCH_WAIT_EN` undefined: FWAIT is unreachable, and code 11 is treated as an unused code (→ INIT).

## Test plan
- Reset: `clear`=1 for 2 cycles → `state`=0, `pc_clr`=1, `ir`=0, every other output 0. Release `clear` → next states are 1, then 2.
- ADD: ROM word 0 = 16'h3123 →
  - FETCH has `pc_up`=1; after FETCH, `ir`=16'h3123.
  - State 8 is reached 2 cycles after FETCH, with `rf_ra_addr`=1, `rf_rb_addr`=2, `rf_w_addr`=3, `alu_s0`=1, `rf_w_en`=1.
- LOAD 16'h2A55 → LOAD_A then LOAD_B, both with `d_addr`=8'hA5, `rf_s`=1, `rf_w_addr`=5. `rf_w_en`=1 in LOAD_B only. Total is 4 cycles.
- STORE 16'h1FF7 → exactly one cycle with `d_wr`=1, `d_addr`=8'hFF, `rf_ra_addr`=7.
  - Opcode 16'h9000 runs as NOOP (state 4), with no write strobes.
- HALT 16'h5000 →
  - `halted`=1 and `state`=10 held for 20+ cycles, with `pc_up` never high.
  - Then `clear` → INIT.
- `clear` asserted during LOAD_A → next state is INIT, and `rf_w_en` stays 0. Repeat the ADD case with `FETCH_WAIT_EN` defined → state 11 precedes every FETCH, and each instruction takes 1 extra cycle.

Source files
------------

// File: rtl/proc_controller.sv
// -----------------------------------------------------------------------------
// proc_controller
//
// Fetch/decode/execute controller for the ProjectB processor. It requests PC
// increments, captures each ROM word into the instruction register and
// sequences the data memory, register file and ALU strobes for every opcode.
// Moore FSM: all datapath controls are decoded from the current state and IR.
//
// Optional feature macro: FETCH_WAIT_EN
//   defined   -> an FWAIT state (code 11) is inserted before every FETCH so a
//                ROM with 2-cycle read latency can be used.
//   undefined -> FWAIT is unreachable and code 11 falls back to INIT.
//
// Ports
//   clk        in   system clock, rising edge
//   clear      in   synchronous active-high reset
//   instr      in   [15:0] instruction ROM read data (registered read of pc_addr)
//   pc_addr    in   [7:0]  current PC value, status only
//   pc_up      out  PC increment request (FETCH)
//   pc_clr     out  PC clear request (INIT)
//   ir         out  [15:0] instruction register
//   d_addr     out  [7:0]  data memory address
//   d_wr       out  data memory write enable
//   rf_s       out  register file write-data select (1 = memory, 0 = ALU)
//   rf_w_addr  out  [3:0]  register file write address
//   rf_w_en    out  register file write enable
//   rf_ra_addr out  [3:0]  register file read port A address
//   rf_rb_addr out  [3:0]  register file read port B address
//   alu_s0     out  [2:0]  ALU function (0 pass A, 1 A+B, 2 A-B)
//   state      out  [3:0]  current state encoding
//   halted     out  high while in HALT
// -----------------------------------------------------------------------------
module proc_controller (
  input  logic        clk,
  input  logic        clear,
  input  logic [15:0] instr,
  input  logic [7:0]  pc_addr,
  output logic        pc_up,
  output logic        pc_clr,
  output logic [15:0] ir,
  output logic [7:0]  d_addr,
  output logic        d_wr,
  output logic        rf_s,
  output logic [3:0]  rf_w_addr,
  output logic        rf_w_en,
  output logic [3:0]  rf_ra_addr,
  output logic [3:0]  rf_rb_addr,
  output logic [2:0]  alu_s0,
  output logic [3:0]  state,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_INIT   = 4'd0,
    S_WAIT   = 4'd1,
    S_FETCH  = 4'd2,
    S_DECODE = 4'd3,
    S_NOOP   = 4'd4,
    S_LOAD_A = 4'd5,
    S_LOAD_B = 4'd6,
    S_STORE  = 4'd7,
    S_ADD    = 4'd8,
    S_SUB    = 4'd9,
    S_HALT   = 4'd10,
    S_FWAIT  = 4'd11
  } state_t;

  // State entered whenever a new fetch is about to start.
`ifdef FETCH_WAIT_EN
  localparam state_t S_REFETCH = S_FWAIT;
`else
  localparam state_t S_REFETCH = S_FETCH;
`endif

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  // The PC value is only informational for this block.
  logic unused_pc_addr;
  assign unused_pc_addr = ^pc_addr;

  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= S_INIT;
      ir_q    <= 16'h0000;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next-state and IR capture.
  always_comb begin
    state_d = S_INIT;
    ir_d    = ir_q;
    case (state_q)
      S_INIT:   state_d = S_WAIT;
      S_WAIT:   state_d = S_REFETCH;
`ifdef FETCH_WAIT_EN
      S_FWAIT:  state_d = S_FETCH;
`endif
      S_FETCH: begin
        state_d = S_DECODE;
        ir_d    = instr;
      end
      S_DECODE: begin
        case (ir_q[15:12])
          4'd1:    state_d = S_STORE;
          4'd2:    state_d = S_LOAD_A;
          4'd3:    state_d = S_ADD;
          4'd4:    state_d = S_SUB;
          4'd5:    state_d = S_HALT;
          default: state_d = S_NOOP;   // opcode 0 and 6..15
        endcase
      end
      S_LOAD_A: state_d = S_LOAD_B;
      S_NOOP, S_LOAD_B, S_STORE, S_ADD, S_SUB: state_d = S_REFETCH;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_INIT;      // unused codes recover to INIT
    endcase
  end

  // Moore output decode.
  always_comb begin
    pc_up      = 1'b0;
    pc_clr     = 1'b0;
    d_addr     = 8'h00;
    d_wr       = 1'b0;
    rf_s       = 1'b0;
    rf_w_addr  = 4'h0;
    rf_w_en    = 1'b0;
    rf_ra_addr = 4'h0;
    rf_rb_addr = 4'h0;
    alu_s0     = 3'd0;
    halted     = 1'b0;
    case (state_q)
      S_INIT:  pc_clr = 1'b1;
      S_FETCH: pc_up  = 1'b1;
      S_STORE: begin
        d_addr     = ir_q[11:4];
        rf_ra_addr = ir_q[3:0];
        alu_s0     = 3'd0;           // pass A straight to memory
        d_wr       = 1'b1;
      end
      S_LOAD_A, S_LOAD_B: begin
        d_addr    = ir_q[11:4];
        rf_s      = 1'b1;
        rf_w_addr = ir_q[3:0];
        // Write only in the second cycle, once memory data has settled.
        rf_w_en   = (state_q == S_LOAD_B);
      end
      S_ADD, S_SUB: begin
        rf_ra_addr = ir_q[11:8];
        rf_rb_addr = ir_q[7:4];
        rf_w_addr  = ir_q[3:0];
        alu_s0     = (state_q == S_ADD) ? 3'd1 : 3'd2;
        rf_w_en    = 1'b1;
      end
      S_HALT:  halted = 1'b1;
      default: ;
    endcase
  end

  assign ir    = ir_q;
  assign state = state_q;

endmodule

// File: tb/tb_proc_controller.sv
// -----------------------------------------------------------------------------
// tb_proc_controller
//
// Bench for proc_controller. A small PC + registered-read ROM environment feeds
// the DUT. The expected behaviour is a per-cycle plan of (state, IR) built from
// the program listing, turned into expected outputs by the per-state output
// table; a negedge process compares every output on every planned cycle.
// A few literal checks pin latency, strobe counts and decoded fields.
// -----------------------------------------------------------------------------
module tb_proc_controller;

  localparam logic [3:0] ST_INIT = 4'd0, ST_WAIT = 4'd1, ST_FETCH = 4'd2,
                         ST_DECODE = 4'd3, ST_NOOP = 4'd4, ST_LOAD_A = 4'd5,
                         ST_LOAD_B = 4'd6, ST_STORE = 4'd7, ST_ADD = 4'd8,
                         ST_SUB = 4'd9, ST_HALT = 4'd10, ST_FWAIT = 4'd11;

  logic        clk = 1'b0;
  logic        clear;
  logic [15:0] instr;
  logic [7:0]  pc_addr;
  logic        pc_up, pc_clr, d_wr, rf_s, rf_w_en, halted;
  logic [15:0] ir;
  logic [7:0]  d_addr;
  logic [3:0]  rf_w_addr, rf_ra_addr, rf_rb_addr, state;
  logic [2:0]  alu_s0;

  always #5 clk = ~clk;

  proc_controller dut (
    .clk        (clk),
    .clear      (clear),
    .instr      (instr),
    .pc_addr    (pc_addr),
    .pc_up      (pc_up),
    .pc_clr     (pc_clr),
    .ir         (ir),
    .d_addr     (d_addr),
    .d_wr       (d_wr),
    .rf_s       (rf_s),
    .rf_w_addr  (rf_w_addr),
    .rf_w_en    (rf_w_en),
    .rf_ra_addr (rf_ra_addr),
    .rf_rb_addr (rf_rb_addr),
    .alu_s0     (alu_s0),
    .state      (state),
    .halted     (halted)
  );

  // ---------------- PC and ROM environment ----------------
  logic [15:0] rom [256];
  logic [7:0]  pc = 8'h00;
  logic [15:0] rom_q = 16'h0000;

  always @(posedge clk) begin
    rom_q <= rom[pc];
    if (pc_clr)     pc <= 8'h00;
    else if (pc_up) pc <= pc + 8'd1;
  end
  assign pc_addr = pc;
  assign instr   = rom_q;

  // ---------------- Model ----------------
  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ir;
  } plan_t;

  typedef struct packed {
    logic [3:0]  st;
    logic [15:0] ir;
    logic        pc_up, pc_clr, d_wr, rf_s, we, halted;
    logic [7:0]  d_addr;
    logic [3:0]  wa, ra, rb;
    logic [2:0]  alu;
  } exp_t;

  plan_t plan_q[$];
  exp_t  exp_r;
  logic  exp_valid = 1'b0;
  int    tests = 0;
  int    fails = 0;
  int    cyc = 0;
  logic [15:0] model_ir;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, act, req);
    end
  endtask

  // Output table: what each state must drive given the IR.
  function automatic exp_t outputs_for(input logic [3:0] st, input logic [15:0] w);
    exp_t e;
    e = '0;
    e.st = st;
    e.ir = w;
    case (st)
      ST_INIT:  e.pc_clr = 1'b1;
      ST_FETCH: e.pc_up  = 1'b1;
      ST_STORE: begin e.d_addr = w[11:4]; e.ra = w[3:0]; e.d_wr = 1'b1; end
      ST_LOAD_A, ST_LOAD_B: begin
        e.d_addr = w[11:4]; e.rf_s = 1'b1; e.wa = w[3:0]; e.we = (st == ST_LOAD_B);
      end
      ST_ADD, ST_SUB: begin
        e.ra = w[11:8]; e.rb = w[7:4]; e.wa = w[3:0]; e.we = 1'b1;
        e.alu = (st == ST_ADD) ? 3'd1 : 3'd2;
      end
      ST_HALT: e.halted = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

  function automatic plan_t mk(input logic [3:0] st, input logic [15:0] w);
    plan_t p;
    p.st = st;
    p.ir = w;
    return p;
  endfunction

  // Plan the cycle-by-cycle (state, IR) trace of the ROM program from address 0
  // after reset, up to and including the first HALT cycle.
  task automatic plan_program(input int max_words);
    logic [15:0] w;
    model_ir = 16'h0000;
    plan_q.push_back(mk(ST_WAIT, model_ir));
    for (int a = 0; a < max_words; a++) begin
      w = rom[a];
`ifdef FETCH_WAIT_EN
      plan_q.push_back(mk(ST_FWAIT, model_ir));
`endif
      plan_q.push_back(mk(ST_FETCH, model_ir));
      model_ir = w;
      plan_q.push_back(mk(ST_DECODE, model_ir));
      case (w[15:12])
        4'd1: plan_q.push_back(mk(ST_STORE, w));
        4'd2: begin plan_q.push_back(mk(ST_LOAD_A, w)); plan_q.push_back(mk(ST_LOAD_B, w)); end
        4'd3: plan_q.push_back(mk(ST_ADD, w));
        4'd4: plan_q.push_back(mk(ST_SUB, w));
        4'd5: begin plan_q.push_back(mk(ST_HALT, w)); return; end
        default: plan_q.push_back(mk(ST_NOOP, w));
      endcase
    end
  endtask

  // Advance one clock and publish the expectation for the new cycle.
  task automatic step();
    plan_t p;
    @(posedge clk);
    #1;
    cyc++;
    if (plan_q.size() == 0) begin
      exp_valid = 1'b0;
      chk("plan_underrun", 32'd1, 32'd0);
    end else begin
      p = plan_q.pop_front();
      exp_r = outputs_for(p.st, p.ir);
      exp_valid = 1'b1;
    end
  endtask

  // Compare process: every output on every planned cycle.
  always @(negedge clk) begin
    if (exp_valid) begin
      chk("state",      {28'd0, state},      {28'd0, exp_r.st});
      chk("ir",         {16'd0, ir},         {16'd0, exp_r.ir});
      chk("pc_up",      {31'd0, pc_up},      {31'd0, exp_r.pc_up});
      chk("pc_clr",     {31'd0, pc_clr},     {31'd0, exp_r.pc_clr});
      chk("d_addr",     {24'd0, d_addr},     {24'd0, exp_r.d_addr});
      chk("d_wr",       {31'd0, d_wr},       {31'd0, exp_r.d_wr});
      chk("rf_s",       {31'd0, rf_s},       {31'd0, exp_r.rf_s});
      chk("rf_w_addr",  {28'd0, rf_w_addr},  {28'd0, exp_r.wa});
      chk("rf_w_en",    {31'd0, rf_w_en},    {31'd0, exp_r.we});
      chk("rf_ra_addr", {28'd0, rf_ra_addr}, {28'd0, exp_r.ra});
      chk("rf_rb_addr", {28'd0, rf_rb_addr}, {28'd0, exp_r.rb});
      chk("alu_s0",     {29'd0, alu_s0},     {29'd0, exp_r.alu});
      chk("halted",     {31'd0, halted},     {31'd0, exp_r.halted});
    end
  end

  // ---------------- Directed stimulus ----------------
  int fetch_cyc, add_cyc, n_pcup, n_we, n_dwr, n_ld, n_halt;

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    rom[0] = 16'h3123;   // ADD r3 = r1 + r2
    rom[1] = 16'h2A55;   // LOAD r5 <- mem[A5]
    rom[2] = 16'h1FF7;   // STORE mem[FF] <- r7
    rom[3] = 16'h9000;   // unused opcode, runs as NOOP
    rom[4] = 16'h4ABC;   // SUB rC = rA - rB
    rom[5] = 16'hF0FF;   // unused opcode, runs as NOOP
    rom[6] = 16'h5000;   // HALT

    // Reset held for two cycles.
    clear = 1'b1;
    plan_q.push_back(mk(ST_INIT, 16'h0000));
    plan_q.push_back(mk(ST_INIT, 16'h0000));
    step();
    step();
    chk("rst_state_lit",  {28'd0, state}, 32'd0);
    chk("rst_ir_lit",     {16'd0, ir},    32'd0);
    chk("rst_pc_clr_lit", {31'd0, pc_clr}, 32'd1);
    clear = 1'b0;

    // Program run, then HALT held for 22 more cycles.
    plan_program(16);
    for (int i = 0; i < 22; i++) plan_q.push_back(mk(ST_HALT, 16'h5000));
    fetch_cyc = -1; add_cyc = -1;
    n_pcup = 0; n_we = 0; n_dwr = 0; n_ld = 0; n_halt = 0;
    while (plan_q.size() > 0) begin
      step();
      if (state == ST_WAIT) chk("wait_after_init_lit", {31'd0, pc_clr}, 32'd0);
      if (state == ST_FETCH && fetch_cyc < 0) fetch_cyc = cyc;
      if (fetch_cyc >= 0 && cyc == fetch_cyc + 1)
        chk("ir_after_fetch_lit", {16'd0, ir}, 32'h3123);
      if (state == ST_ADD && add_cyc < 0) begin
        add_cyc = cyc;
        chk("add_ra_lit",  {28'd0, rf_ra_addr}, 32'd1);
        chk("add_rb_lit",  {28'd0, rf_rb_addr}, 32'd2);
        chk("add_wa_lit",  {28'd0, rf_w_addr},  32'd3);
        chk("add_alu_lit", {29'd0, alu_s0},     32'd1);
      end
      if (state == ST_LOAD_A || state == ST_LOAD_B) begin
        n_ld++;
        chk("load_daddr_lit", {24'd0, d_addr}, 32'hA5);
      end
      if (state == ST_STORE) chk("store_daddr_lit", {24'd0, d_addr}, 32'hFF);
      if (halted) n_halt++;
      n_pcup += int'(pc_up);
      n_we   += int'(rf_w_en);
      n_dwr  += int'(d_wr);
    end
    chk("fetch_to_add_lit", add_cyc - fetch_cyc, 32'd2);
    chk("pc_up_count_lit",  n_pcup, 32'd7);
    chk("rf_w_en_count_lit", n_we,  32'd3);
    chk("d_wr_count_lit",   n_dwr,  32'd1);
    chk("load_cycles_lit",  n_ld,   32'd2);
    chk("halt_cycles_lit",  n_halt, 32'd23);

    // Clear out of HALT.
    clear = 1'b1;
    rom[0] = 16'h2A55;
    plan_q.push_back(mk(ST_INIT, 16'h0000));
    plan_q.push_back(mk(ST_INIT, 16'h0000));
    step();
    chk("halt_clear_lit", {28'd0, state}, 32'd0);
    step();
    clear = 1'b0;

    // LOAD aborted by clear during LOAD_A.
    plan_q.push_back(mk(ST_WAIT, 16'h0000));
`ifdef FETCH_WAIT_EN
    plan_q.push_back(mk(ST_FWAIT, 16'h0000));
`endif
    plan_q.push_back(mk(ST_FETCH, 16'h0000));
    plan_q.push_back(mk(ST_DECODE, 16'h2A55));
    plan_q.push_back(mk(ST_LOAD_A, 16'h2A55));
    while (plan_q.size() > 0) step();
    chk("in_load_a_lit", {28'd0, state}, 32'd5);
    clear = 1'b1;
    plan_q.push_back(mk(ST_INIT, 16'h0000));
    plan_q.push_back(mk(ST_INIT, 16'h0000));
    step();
    chk("abort_state_lit", {28'd0, state},   32'd0);
    chk("abort_we_lit",    {31'd0, rf_w_en}, 32'd0);
    step();

    @(negedge clk);
    exp_valid = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
